programmable_tick_generator: RTL

PROGRAMMABLE_TICK_GENERATOR -- requirements
Module: programmable_tick_generator

---
 rtl/programmable_tick_generator.sv | 105 ++++++++++
 1 files changed

// File: rtl/programmable_tick_generator.sv
// Programmable tick generator.
// A bank of independent down-counting channels. Each channel emits a single
// cycle tick every Re cycles (periodic mode) or once after being armed by
// Start (one-shot mode). Re is the channel's reload register, with zero
// treated as one so a channel can never stall. Reload registers are written
// one channel at a time through the LoadValid/LoadChannel/LoadValue port.
// All outputs come straight from registers.

module programmable_tick_generator #(
    parameter int NrOfChannels  = 4,
    parameter int NrOfBits      = 16,
    parameter int DefaultReload = 1
) (
    input  logic                                                 FPGAClock,
    input  logic                                                 FPGAResetN,
    input  logic [NrOfChannels-1:0]                              Enable,
    input  logic [NrOfChannels-1:0]                              Start,
    input  logic [NrOfChannels-1:0]                              OneShot,
    input  logic                                                 LoadValid,
    input  logic [((NrOfChannels > 1) ? $clog2(NrOfChannels) : 1)-1:0] LoadChannel,
    input  logic [NrOfBits-1:0]                                  LoadValue,
    output logic [NrOfChannels-1:0]                              FPGATick,
    output logic [NrOfChannels-1:0]                              Active
);

    // A reload value of zero behaves exactly like a reload value of one.
    function automatic logic [NrOfBits-1:0] effective_reload(input logic [NrOfBits-1:0] value);
        return (value == '0) ? NrOfBits'(1) : value;
    endfunction

    for (genvar ch = 0; ch < NrOfChannels; ch++) begin : g_channel

        logic [NrOfBits-1:0] count_q;
        logic [NrOfBits-1:0] reload_q;
        logic                tick_q;
        logic                armed_q;

        logic                write_hit;
        logic [NrOfBits-1:0] start_source;
        logic [NrOfBits-1:0] start_count;
        logic [NrOfBits-1:0] wrap_count;

        // A write addressed to a channel index that does not exist never
        // matches any channel, so it is silently dropped.
        assign write_hit = LoadValid && (int'(LoadChannel) == ch);

        // Start uses the value being written this very cycle, so a software
        // "write reload and start" lands in a single cycle.
        assign start_source = write_hit ? LoadValue : reload_q;
        assign start_count  = effective_reload(start_source) - NrOfBits'(1);

        // Terminal-count reloads use the stored register only; a write in
        // flight affects the reload that follows it.
        assign wrap_count = effective_reload(reload_q) - NrOfBits'(1);

        // Reload register: restored to its default on reset, else updated by
        // writes aimed at this channel; never touches the running count.
        always_ff @(posedge FPGAClock) begin
            if (!FPGAResetN) begin
                reload_q <= NrOfBits'(DefaultReload);
            end else if (write_hit) begin
                reload_q <= LoadValue;
            end
        end

        // Counter, tick and armed state: Start beats everything but reset, the
        // tick is a one-cycle pulse, periodic mode keeps the channel armed.
        always_ff @(posedge FPGAClock) begin
            if (!FPGAResetN) begin
                count_q <= '0;
                tick_q  <= 1'b0;
                armed_q <= 1'b0;
            end else if (Start[ch]) begin
                count_q <= start_count;
                tick_q  <= 1'b0;
                armed_q <= 1'b1;
            end else begin
                tick_q <= 1'b0;
                if (!OneShot[ch]) begin
                    armed_q <= 1'b1;
                    if (Enable[ch]) begin
                        if (count_q == '0) begin
                            tick_q  <= 1'b1;
                            count_q <= wrap_count;
                        end else begin
                            count_q <= count_q - NrOfBits'(1);
                        end
                    end
                end else if (Enable[ch] && armed_q) begin
                    if (count_q == '0) begin
                        tick_q  <= 1'b1;
                        armed_q <= 1'b0;
                    end else begin
                        count_q <= count_q - NrOfBits'(1);
                    end
                end
            end
        end

        assign FPGATick[ch] = tick_q;
        assign Active[ch]   = armed_q;

    end

endmodule
